// File: rtl/hawk_cpu_stall_arb.sv
// rtl/hawk_cpu_stall_arb.sv - round-robin arbiter between CPU read/write stall paths and the HAWK page lookup
// Optional watchdog in WAIT_RSP enabled by HACD_STALL_ARB_TIMEOUT_EN.
module hawk_cpu_stall_arb #(
  parameter int HPPA_WIDTH     = 48,
  parameter int RETRY_DELAY    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hawk_inactive,
  input  logic                  rd_req_valid,
  input  logic [HPPA_WIDTH-1:0] rd_req_hppa,
  input  logic                  wr_req_valid,
  input  logic [HPPA_WIDTH-1:0] wr_req_hppa,
  output logic                  rd_ovrd_allow,
  output logic [HPPA_WIDTH-1:0] rd_ovrd_ppa,
  output logic                  wr_ovrd_allow,
  output logic [HPPA_WIDTH-1:0] wr_ovrd_ppa,
  output logic                  lkup_req_valid,
  input  logic                  lkup_req_ready,
  output logic [HPPA_WIDTH-1:0] lkup_req_hppa,
  output logic                  lkup_req_src,
  input  logic                  lkup_rsp_valid,
  input  logic                  lkup_rsp_allow,
  input  logic [HPPA_WIDTH-1:0] lkup_rsp_ppa,
  output logic                  err_timeout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_RSP = 3'd2;
  localparam logic [2:0] S_BACKOFF  = 3'd3;
  localparam logic [2:0] S_GRANT    = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;

  localparam logic [7:0] BACKOFF_LOAD = 8'(RETRY_DELAY - 1);

  logic [2:0]            r_state;
  logic                  r_src;
  logic                  r_last_src;
  logic [HPPA_WIDTH-1:0] r_hppa;
  logic [7:0]            r_bo_cnt;
  logic                  r_lkup_valid;
  logic                  r_rd_allow;
  logic                  r_wr_allow;
  logic [HPPA_WIDTH-1:0] r_rd_ppa;
  logic [HPPA_WIDTH-1:0] r_wr_ppa;
  logic                  r_err;

  logic                  w_pick_wr;
  logic                  w_src_valid;
  logic                  w_to_hit;
  logic [HPPA_WIDTH-1:0] w_grant_ppa;

  // On a tie the path opposite the last granted one wins.
  always_comb begin
    w_pick_wr = wr_req_valid;
    if (rd_req_valid && wr_req_valid) begin
      w_pick_wr = ~r_last_src;
    end
  end

  assign w_src_valid = r_src ? wr_req_valid : rd_req_valid;
  assign w_grant_ppa = (lkup_rsp_valid && lkup_rsp_allow) ? lkup_rsp_ppa : r_hppa;

`ifdef HACD_STALL_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  assign w_to_hit = (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_WAIT_RSP) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end else begin
        r_to_cnt <= '0;
      end
      if ((r_state == S_WAIT_RSP) && !lkup_rsp_valid && w_to_hit) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  // Watchdog disabled: the compare is constant false.
  assign w_to_hit = (TIMEOUT_CYCLES < 0);

  always_ff @(posedge clk) begin
    r_err <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_src        <= 1'b0;
      r_last_src   <= 1'b1;
      r_hppa       <= '0;
      r_bo_cnt     <= '0;
      r_lkup_valid <= 1'b0;
      r_rd_allow   <= 1'b0;
      r_wr_allow   <= 1'b0;
      r_rd_ppa     <= '0;
      r_wr_ppa     <= '0;
    end else begin
      r_rd_allow <= 1'b0;
      r_wr_allow <= 1'b0;
      r_rd_ppa   <= '0;
      r_wr_ppa   <= '0;
      case (r_state)
        S_IDLE: begin
          if (!hawk_inactive && (rd_req_valid || wr_req_valid)) begin
            r_src        <= w_pick_wr;
            r_hppa       <= w_pick_wr ? wr_req_hppa : rd_req_hppa;
            r_lkup_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (hawk_inactive) begin
            r_lkup_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else if (lkup_req_ready) begin
            r_lkup_valid <= 1'b0;
            r_state      <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          // A watchdog expiry grants the identity mapping.
          if ((lkup_rsp_valid && lkup_rsp_allow) || (!lkup_rsp_valid && w_to_hit)) begin
            r_rd_allow <= ~r_src;
            r_wr_allow <= r_src;
            r_rd_ppa   <= r_src ? '0 : w_grant_ppa;
            r_wr_ppa   <= r_src ? w_grant_ppa : '0;
            r_state    <= S_GRANT;
          end else if (lkup_rsp_valid) begin
            r_bo_cnt <= BACKOFF_LOAD;
            r_state  <= S_BACKOFF;
          end
        end
        S_BACKOFF: begin
          if (r_bo_cnt == 8'd0) begin
            r_lkup_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
            r_bo_cnt <= r_bo_cnt - 8'd1;
          end
        end
        S_GRANT: begin
          r_last_src <= r_src;
          r_state    <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!w_src_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_lkup_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign lkup_req_valid = r_lkup_valid;
  assign lkup_req_hppa  = r_hppa;
  assign lkup_req_src   = r_src;
  assign rd_ovrd_allow  = r_rd_allow;
  assign rd_ovrd_ppa    = r_rd_ppa;
  assign wr_ovrd_allow  = r_wr_allow;
  assign wr_ovrd_ppa    = r_wr_ppa;
  assign err_timeout    = r_err;

endmodule
